// File: rtl/pwm_capture.sv
// pwm_capture: decodes a servo/ESC PWM input into an 8-bit command value.
// Measures each pulse's high time in prescaled ticks, validates it, maps MIN_W..MAX_W
// linearly onto 0..255 and flags rejected pulses and loss of signal.
// Optional feature: define PWM_CAPTURE_AVG_EN to average each accepted value with the
// previous one (first accepted value after reset / signal loss is loaded raw).
module pwm_capture #(
    parameter int unsigned PRESCALE = 200,
    parameter int unsigned MIN_W    = 25,
    parameter int unsigned MAX_W    = 125,
    parameter int unsigned TOL      = 5,
    parameter int unsigned TIMEOUT  = 3000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       pwm_in,
    output logic [7:0] value,
    output logic       valid,
    output logic       err,
    output logic       signal_lost,
    output logic [9:0] width
);

    localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned ToW = $clog2(TIMEOUT + 1);

    localparam logic [PsW-1:0] PsMax = PsW'(PRESCALE - 1);
    localparam logic [ToW-1:0] ToMax = ToW'(TIMEOUT);
    localparam logic [9:0]     RejLo = 10'(MIN_W - TOL);
    localparam logic [9:0]     RejHi = 10'(MAX_W + TOL);
    localparam logic [9:0]     MinW  = 10'(MIN_W);
    localparam logic [9:0]     MaxW  = 10'(MAX_W);
    localparam logic [17:0]    Span  = 18'(MAX_W - MIN_W);

    typedef enum logic [1:0] {StWaitLow, StIdle, StHigh} state_e;

    state_e         state_q, state_d;
    logic           sync1_q, sync2_q, sync3_q;
    logic           rise, fall, tick;
    logic [PsW-1:0] psc_q;
    logic [9:0]     cnt_q, cnt_d, cnt_inc;
    logic [ToW-1:0] to_q, to_d;
    logic           lost_q, lost_d;
    logic [7:0]     value_q, value_d;
    logic [9:0]     width_q, width_d;
    logic           valid_q, valid_d;
    logic           err_q, err_d;
    logic [17:0]    scaled;
    logic [7:0]     new_val, accept_val;

    assign rise = sync2_q & ~sync3_q;
    assign fall = ~sync2_q & sync3_q;
    assign tick = (psc_q == PsMax);

    // Input synchronizer plus edge-detect stage. Reset to 1 so a pulse already in
    // progress at reset release is not seen as a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Free-running measurement tick prescaler, independent of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q <= '0;
        end else begin
            psc_q <= tick ? '0 : psc_q + 1'b1;
        end
    end

    // Width-to-value mapping; the tick landing on the fall cycle still counts.
    always_comb begin
        cnt_inc = cnt_q + {9'd0, tick};
        scaled  = ({8'd0, cnt_inc} - {8'd0, MinW}) * 18'd255;
        if (cnt_inc < MinW) begin
            new_val = 8'd0;
        end else if (cnt_inc > MaxW) begin
            new_val = 8'hff;
        end else begin
            new_val = 8'(scaled / Span);
        end
    end

`ifdef PWM_CAPTURE_AVG_EN
    logic [8:0] avg_sum;

    // Rounded average with the previous value; signal_lost marks a fresh start.
    always_comb begin
        avg_sum    = {1'b0, value_q} + {1'b0, new_val} + 9'd1;
        accept_val = lost_q ? new_val : 8'(avg_sum >> 1);
    end
`else
    assign accept_val = new_val;
`endif

    // Capture FSM: next state, high counter and result strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        width_d = width_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (!en) begin
            state_d = StWaitLow;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StWaitLow: begin
                    if (!sync2_q) state_d = StIdle;
                end
                StIdle: begin
                    if (rise) begin
                        cnt_d   = '0;
                        state_d = StHigh;
                    end
                end
                StHigh: begin
                    cnt_d = cnt_inc;
                    if (fall) begin
                        state_d = StIdle;
                        width_d = cnt_inc;
                        if (cnt_inc < RejLo || cnt_inc > RejHi) begin
                            err_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            value_d = accept_val;
                        end
                    end else if (cnt_inc > RejHi) begin
                        // Stuck-high pulse: reject now, ignore its eventual fall.
                        err_d   = 1'b1;
                        width_d = cnt_inc;
                        state_d = StWaitLow;
                    end
                end
                default: state_d = StWaitLow;
            endcase
        end
    end

    // Saturating timeout counter and signal-lost flag.
    always_comb begin
        to_d   = to_q;
        lost_d = lost_q;
        if (!en) begin
            to_d   = '0;
            lost_d = 1'b1;
        end else if (valid_d) begin
            to_d   = '0;
            lost_d = 1'b0;
        end else begin
            if (tick && to_q != ToMax) to_d = to_q + 1'b1;
            if (to_d >= ToMax) lost_d = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StWaitLow;
            cnt_q   <= '0;
            to_q    <= '0;
            lost_q  <= 1'b1;
            value_q <= '0;
            width_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            lost_q  <= lost_d;
            value_q <= value_d;
            width_q <= width_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign value       = value_q;
    assign valid       = valid_q;
    assign err         = err_q;
    assign signal_lost = lost_q;
    assign width       = width_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture. Uses a short prescaler so the full
// 3000-tick timeout fits in a short run. Pulses are whole multiples of the
// prescaler, so their measured width is exact regardless of tick phase.
module tb_pwm_capture;

    localparam int P = 4;

    logic       clk, rst_n, en, pwm_in;
    logic [7:0] value;
    logic       valid, err, signal_lost;
    logic [9:0] width;

    pwm_capture #(
        .PRESCALE (P),
        .MIN_W    (25),
        .MAX_W    (125),
        .TOL      (5),
        .TIMEOUT  (3000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .pwm_in      (pwm_in),
        .value       (value),
        .valid       (valid),
        .err         (err),
        .signal_lost (signal_lost),
        .width       (width)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int ticks;
        bit exp_valid;
        bit exp_err;
        int exp_value;
    } vec_t;

    vec_t tbl[8];

    int n_checks = 0;
    int n_fail   = 0;
    int hv, he, lv, le, strobe_c, hi_err_c, stray;
    int strobe_value, strobe_width, strobe_lost;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int cyc);
        for (int i = 0; i < cyc; i++) begin
            step();
            if (valid) stray++;
            if (err) stray++;
        end
    endtask

    // Drive one pulse of n ticks followed by gap low cycles, recording all strobes.
    task automatic send_pulse(input int n, input int gap);
        hv = 0; he = 0; lv = 0; le = 0; strobe_c = -1; hi_err_c = -1;
        pwm_in = 1'b1;
        for (int c = 1; c <= n * P; c++) begin
            step();
            if (valid) hv++;
            if (err) begin
                he++;
                if (hi_err_c < 0) hi_err_c = c;
            end
        end
        pwm_in = 1'b0;
        for (int c = 1; c <= gap; c++) begin
            step();
            if (valid) lv++;
            if (err) le++;
            if ((valid || err) && strobe_c < 0) begin
                strobe_c     = c;
                strobe_value = int'(value);
                strobe_width = int'(width);
                strobe_lost  = int'(signal_lost);
            end
        end
    endtask

    task automatic check_pulse(input string name, input int n, input bit ev, input bit ee,
                               input int exp_value);
        check($sformatf("%s strobes while high", name), hv + he, 0);
        check($sformatf("%s valid cycles", name), lv, int'(ev));
        check($sformatf("%s err cycles", name), le, int'(ee));
        if (ev || ee) begin
            check($sformatf("%s latency", name), strobe_c, 3);
            check($sformatf("%s value", name), strobe_value, exp_value);
            check($sformatf("%s width", name), strobe_width, n);
        end
        if (ev) check($sformatf("%s signal_lost at valid", name), strobe_lost, 0);
    endtask

    function automatic int map_raw(input int n);
        if (n < 25) return 0;
        if (n > 125) return 255;
        return (n - 25) * 255 / 100;
    endfunction

    int  prev_val;
    bit  first;
    int  n, gap, raw, exp_v;
    bit  exp_e;

    initial begin
        // Directed vectors: ticks, valid, err, expected value
`ifdef PWM_CAPTURE_AVG_EN
        tbl[0] = '{75,  1'b1, 1'b0, 127};
        tbl[1] = '{25,  1'b1, 1'b0, 64};
        tbl[2] = '{125, 1'b1, 1'b0, 160};
        tbl[3] = '{22,  1'b1, 1'b0, 80};
        tbl[4] = '{128, 1'b1, 1'b0, 168};
        tbl[5] = '{19,  1'b0, 1'b1, 168};
        tbl[6] = '{50,  1'b1, 1'b0, 116};
        tbl[7] = '{100, 1'b1, 1'b0, 154};
`else
        tbl[0] = '{75,  1'b1, 1'b0, 127};
        tbl[1] = '{25,  1'b1, 1'b0, 0};
        tbl[2] = '{125, 1'b1, 1'b0, 255};
        tbl[3] = '{22,  1'b1, 1'b0, 0};
        tbl[4] = '{128, 1'b1, 1'b0, 255};
        tbl[5] = '{19,  1'b0, 1'b1, 255};
        tbl[6] = '{50,  1'b1, 1'b0, 63};
        tbl[7] = '{100, 1'b1, 1'b0, 191};
`endif

        rst_n = 1'b0; en = 1'b1; pwm_in = 1'b0; stray = 0;
        repeat (3) step();
        check("reset value", int'(value), 0);
        check("reset valid", int'(valid), 0);
        check("reset err", int'(err), 0);
        check("reset signal_lost", int'(signal_lost), 1);
        check("reset width", int'(width), 0);
        rst_n = 1'b1;
        run(10);

        for (int i = 0; i < 8; i++) begin
            send_pulse(tbl[i].ticks, 40);
            check_pulse($sformatf("tbl%0d", i), tbl[i].ticks, tbl[i].exp_valid,
                        tbl[i].exp_err, tbl[i].exp_value);
        end

        // Stuck high: err as count passes 130, nothing on the later fall.
        send_pulse(140, 40);
        check("ovf err while high", he, 1);
        check("ovf valid while high", hv, 0);
        check("ovf err time", int'(hi_err_c >= 130 * P + 4 && hi_err_c <= 131 * P + 3), 1);
        check("ovf strobes after fall", lv + le, 0);
        check("ovf width", int'(width), 131);
        check("ovf value held", int'(value), tbl[7].exp_value);

        // Enable raised mid-pulse: that pulse is discarded.
        stray = 0;
        en = 1'b0;
        run(2);
        check("en=0 signal_lost", int'(signal_lost), 1);
        pwm_in = 1'b1;
        run(20);
        en = 1'b1;
        run(30 * P);
        pwm_in = 1'b0;
        run(20);
        check("en mid-pulse strobes", stray, 0);
        check("en mid-pulse value held", int'(value), tbl[7].exp_value);
        send_pulse(50, 40);
        check_pulse("after en", 50, 1'b1, 1'b0, 63);

        // Reset mid-pulse, then released with pwm_in still high.
        pwm_in = 1'b1;
        run(10 * P);
        rst_n = 1'b0;
        #1;
        check("mid reset value", int'(value), 0);
        check("mid reset width", int'(width), 0);
        check("mid reset signal_lost", int'(signal_lost), 1);
        step();
        rst_n = 1'b1;
        stray = 0;
        run(30 * P);
        pwm_in = 1'b0;
        run(20);
        check("reset mid-pulse strobes", stray, 0);
        send_pulse(50, 8);
        check_pulse("after reset", 50, 1'b1, 1'b0, 63);

        // Timeout: 5 cycles have passed since valid; land exactly on 2999 and 3000 ticks.
        stray = 0;
        run(2999 * P - 5);
        check("timeout at 2999 ticks", int'(signal_lost), 0);
        run(P);
        check("timeout at 3000 ticks", int'(signal_lost), 1);
        check("timeout strobes", stray, 0);
        send_pulse(100, 20);
        check_pulse("after timeout", 100, 1'b1, 1'b0, 191);
        check("signal_lost cleared", int'(signal_lost), 0);

        // Disable to force a fresh start, then 25 and 125 ticks.
        en = 1'b0;
        run(3);
        check("disable signal_lost", int'(signal_lost), 1);
        en = 1'b1;
        run(5);
        send_pulse(25, 20);
        check_pulse("fresh 25", 25, 1'b1, 1'b0, 0);
        send_pulse(125, 20);
`ifdef PWM_CAPTURE_AVG_EN
        check_pulse("then 125", 125, 1'b1, 1'b0, 128);
        prev_val = 128;
`else
        check_pulse("then 125", 125, 1'b1, 1'b0, 255);
        prev_val = 255;
`endif

        // Randomized pulses against the reference model.
        first = 1'b0;
        for (int i = 0; i < 30; i++) begin
            n     = int'($urandom_range(130, 15));
            gap   = int'($urandom_range(60, 8));
            exp_e = (n < 20) || (n > 130);
            raw   = map_raw(n);
            exp_v = prev_val;
            if (!exp_e) begin
`ifdef PWM_CAPTURE_AVG_EN
                exp_v = first ? raw : (prev_val + raw + 1) / 2;
`else
                exp_v = raw;
`endif
            end
            send_pulse(n, gap);
            check_pulse($sformatf("rnd%0d n=%0d", i, n), n, !exp_e, exp_e, exp_v);
            prev_val = exp_v;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
